// File: rtl/m_cp0_timer_pkg.sv
// Shared constants and helpers for the M-stage CP0 with Count/Compare timer.
package m_cp0_timer_pkg;

    // Register select values seen on CP0Add
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    // Exception codes written into Cause.ExcCode
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // SR / Cause bit positions
    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_TI    = 30;
    localparam int CAUSE_BD    = 31;

    // Width of the IP/IM field in SR and Cause
    localparam int IP_W = 6;

    // Only IM, EXL and IE are software writable in SR
    localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

    // Outcome of the per-cycle interrupt/exception arbitration
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_INT  = 2'd1,
        EV_EXC  = 2'd2
    } cp0_event_e;

    // Assemble the architectural Cause word from its live fields
    function automatic logic [31:0] cause_pack(
        input logic            bd,
        input logic            ti,
        input logic [IP_W-1:0] ip,
        input logic [4:0]      code
    );
        logic [31:0] w;
        w                            = '0;
        w[CAUSE_BD]                  = bd;
        w[CAUSE_TI]                  = ti;
        w[CAUSE_IP_LO +: IP_W]       = ip;
        w[CAUSE_EXC_LO +: 5]         = code;
        return w;
    endfunction

endpackage

// File: rtl/m_cp0_timer_if.sv
// Pipeline-side bundle of the CP0: mtc0/mfc0 access, victim info, interrupts, flush request.
interface m_cp0_timer_if #(
    parameter int NUM_HWINT = 6
) ();
    logic                 WE;
    logic [4:0]           CP0Add;
    logic [31:0]          CP0In;
    logic [31:0]          VPC;
    logic                 BDIn;
    logic [4:0]           ExcCodeIn;
    logic [31:0]          BadVAddrIn;
    logic [NUM_HWINT-1:0] HWInt;
    logic                 EXLClr;
    logic [31:0]          CP0Out;
    logic [31:0]          EPCOut;
    logic                 Req;
    logic                 TimerIRQ;

    // Pipeline side drives requests and consumes CP0 results
    modport master (
        output WE, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, BadVAddrIn, HWInt, EXLClr,
        input  CP0Out, EPCOut, Req, TimerIRQ
    );

    // CP0 side
    modport slave (
        input  WE, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, BadVAddrIn, HWInt, EXLClr,
        output CP0Out, EPCOut, Req, TimerIRQ
    );
endinterface

// File: rtl/m_cp0_timer_timer.sv
// Prescaled Count/Compare timer with sticky match flag (TI).
module m_cp0_timer_timer #(
    parameter int TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    // Prescaler needs at least one bit even when every cycle is a tick
    localparam int            PW         = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          tick;
    logic [31:0]   count_inc;

    assign tick      = (presc_q == PRESC_LAST);
    assign count_inc = count_q + 32'd1;

    // Next-state: a Count write restarts the prescaler; TI is only set by an increment
    // landing on Compare, and a Compare write in the same cycle clears it regardless.
    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we) begin
            count_d = wdata;
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
            count_d = count_inc;
            if (count_inc == compare_q) begin
                ti_d = 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/m_cp0_timer.sv
// M-stage CP0: SR/Cause/EPC/BadVAddr/PRId, interrupt vs exception arbitration, flush
// request, and a prescaled Count/Compare timer folded onto one IP line.
module m_cp0_timer
    import m_cp0_timer_pkg::*;
#(
    parameter int          NUM_HWINT  = 6,
    parameter int          TIMER_LINE = 5,
    parameter int          TIMER_DIV  = 1,
    parameter logic [31:0] EXC_MASK   = 32'h0000_1530,
    parameter logic [31:0] PRID_VAL   = 32'h0000_7A01
) (
    input logic          Clk,
    input logic          Reset,
    m_cp0_timer_if.slave bus
);
    localparam logic [IP_W-1:0] TIMER_BIT = IP_W'(1) << TIMER_LINE;

    logic [31:0]     sr_q, sr_d;
    logic [31:0]     epc_q, epc_d;
    logic [31:0]     badv_q, badv_d;
    logic            bd_q, bd_d;
    logic [4:0]      code_q, code_d;
    logic [IP_W-1:0] ip_q, ip_d;

    logic [IP_W-1:0] hw_ip;
    logic [IP_W-1:0] ip_now;
    logic            int_req;
    logic            exc_req;
    logic            req;
    cp0_event_e      ev;
    logic            wr_ok;
    logic            count_we;
    logic            compare_we;
    logic [31:0]     count_val;
    logic [31:0]     compare_val;
    logic            ti;
    logic [31:0]     rdata;

    // Pending lines: external levels plus the timer flag on its configured line.
    // Bits above NUM_HWINT stay zero, so unused IM bits can never enable anything.
    assign hw_ip  = IP_W'(bus.HWInt);
    assign ip_now = hw_ip | (ti ? TIMER_BIT : '0);

    assign int_req = ~sr_q[SR_EXL] & sr_q[SR_IE] & (|(ip_now & sr_q[SR_IM_LO +: IP_W]));
    assign exc_req = ~int_req & EXC_MASK[bus.ExcCodeIn] & (bus.ExcCodeIn != EXC_INT);
    assign req     = int_req | exc_req;
    assign ev      = int_req ? EV_INT : (exc_req ? EV_EXC : EV_NONE);

    // mtc0 only lands when no exception is being taken
    assign wr_ok      = bus.WE & ~req;
    assign count_we   = wr_ok & (bus.CP0Add == CP0_COUNT);
    assign compare_we = wr_ok & (bus.CP0Add == CP0_COMPARE);

    m_cp0_timer_timer #(
        .TIMER_DIV (TIMER_DIV)
    ) u_timer (
        .clk        (Clk),
        .rst_n      (Reset),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (bus.CP0In),
        .count      (count_val),
        .compare    (compare_val),
        .ti         (ti)
    );

    // Next-state of the exception registers: entry has priority over eret and mtc0,
    // and an SR write beats an eret landing in the same cycle.
    always_comb begin
        sr_d   = sr_q;
        epc_d  = epc_q;
        badv_d = badv_q;
        bd_d   = bd_q;
        code_d = code_q;
        ip_d   = ip_now;
        case (ev)
            EV_INT: begin
                sr_d[SR_EXL] = 1'b1;
                epc_d        = bus.VPC;
                bd_d         = bus.BDIn;
                code_d       = EXC_INT;
            end
            EV_EXC: begin
                sr_d[SR_EXL] = 1'b1;
                epc_d        = bus.VPC;
                bd_d         = bus.BDIn;
                code_d       = bus.ExcCodeIn;
                if ((bus.ExcCodeIn == EXC_ADEL) || (bus.ExcCodeIn == EXC_ADES)) begin
                    badv_d = bus.BadVAddrIn;
                end
            end
            default: begin
                if (bus.EXLClr) begin
                    sr_d[SR_EXL] = 1'b0;
                end
                if (bus.WE) begin
                    case (bus.CP0Add)
                        CP0_SR:  sr_d  = bus.CP0In & SR_WMASK;
                        CP0_EPC: epc_d = bus.CP0In;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Exception register file
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sr_q   <= '0;
            epc_q  <= '0;
            badv_q <= '0;
            bd_q   <= 1'b0;
            code_q <= '0;
            ip_q   <= '0;
        end else begin
            sr_q   <= sr_d;
            epc_q  <= epc_d;
            badv_q <= badv_d;
            bd_q   <= bd_d;
            code_q <= code_d;
            ip_q   <= ip_d;
        end
    end

    // mfc0 read mux on the pre-edge register values; TI is shown live in Cause[30]
    always_comb begin
        rdata = '0;
        case (bus.CP0Add)
            CP0_BADVADDR: rdata = badv_q;
            CP0_COUNT:    rdata = count_val;
            CP0_COMPARE:  rdata = compare_val;
            CP0_SR:       rdata = sr_q;
            CP0_CAUSE:    rdata = cause_pack(bd_q, ti, ip_q, code_q);
            CP0_EPC:      rdata = epc_q;
            CP0_PRID:     rdata = PRID_VAL;
            default:      rdata = '0;
        endcase
    end

    assign bus.CP0Out   = rdata;
    assign bus.EPCOut   = epc_q;
    assign bus.Req      = req;
    assign bus.TimerIRQ = ti;

endmodule

// File: tb/tb_m_cp0_timer.sv
// Self-checking bench for m_cp0_timer: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the CP0 rules.
module tb_m_cp0_timer;

    localparam int          NHW   = 6;
    localparam int          TLINE = 5;
    localparam int          DIV   = 4;
    localparam logic [31:0] XMASK = 32'h0000_1530;
    localparam logic [31:0] PRID  = 32'h0000_7A01;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    m_cp0_timer_if #(.NUM_HWINT(NHW)) bus ();

    m_cp0_timer #(
        .NUM_HWINT  (NHW),
        .TIMER_LINE (TLINE),
        .TIMER_DIV  (DIV),
        .EXC_MASK   (XMASK),
        .PRID_VAL   (PRID)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] sweep_addr [10] = '{5'd0, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd10, 5'd31};
    logic [4:0] rnd_addr   [9]  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd31};
    logic [4:0] rnd_code   [11] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd1, 5'd31};

    // ---------------- behavioural model ----------------
    logic [31:0] m_sr, m_epc, m_badv, m_count, m_compare;
    logic        m_bd, m_ti;
    logic [4:0]  m_code;
    logic [5:0]  m_ipreg;
    int          m_phase;   // cycles elapsed since last Count increment or write

    function automatic void m_reset();
        m_sr = 0; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
        m_bd = 0; m_ti = 0; m_code = 0; m_ipreg = 0; m_phase = 0;
    endfunction

    function automatic logic [5:0] m_ip();
        return 6'(bus.HWInt) | (m_ti ? 6'(1 << TLINE) : 6'd0);
    endfunction

    function automatic logic m_int();
        return !m_sr[1] && m_sr[0] && ((m_ip() & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic m_exc();
        return !m_int() && (bus.ExcCodeIn != 5'd0) && XMASK[bus.ExcCodeIn];
    endfunction

    function automatic logic m_req();
        return m_int() || m_exc();
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_sr;
            5'd13:   return {m_bd, m_ti, 14'd0, m_ipreg, 3'd0, m_code, 2'd0};
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    // Advance model and DUT by one clock with the inputs currently applied
    task automatic step();
        logic [5:0] ip;
        logic       it, ex, rq, kw, cw;
        logic [4:0] a;
        ip = m_ip(); it = m_int(); ex = m_exc(); rq = it || ex; a = bus.CP0Add;
        kw = bus.WE && !rq && (a == 5'd9);
        cw = bus.WE && !rq && (a == 5'd11);
        if (kw) begin
            m_count = bus.CP0In;
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_count = m_count + 32'd1;
                if (m_count == m_compare) m_ti = 1'b1;
            end
        end
        if (cw) begin
            m_compare = bus.CP0In;
            m_ti      = 1'b0;
        end
        m_ipreg = ip;
        if (rq) begin
            m_sr[1] = 1'b1;
            m_epc   = bus.VPC;
            m_bd    = bus.BDIn;
            m_code  = it ? 5'd0 : bus.ExcCodeIn;
            if (ex && (bus.ExcCodeIn == 5'd4 || bus.ExcCodeIn == 5'd5)) m_badv = bus.BadVAddrIn;
        end else begin
            if (bus.EXLClr) m_sr[1] = 1'b0;
            if (bus.WE && a == 5'd12) m_sr = bus.CP0In & 32'h0000_FC03;
            if (bus.WE && a == 5'd14) m_epc = bus.CP0In;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.WE = 0; bus.CP0Add = 0; bus.CP0In = 0; bus.ExcCodeIn = 0;
        bus.EXLClr = 0; bus.BDIn = 0; bus.HWInt = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        bus.WE = 1; bus.CP0Add = a; bus.CP0In = d;
        step();
        idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle(); bus.VPC = 0; bus.BadVAddrIn = 0;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bus.CP0Add = sweep_addr[i]; #1;
            n_cmp++;
            if (bus.CP0Out !== m_read(sweep_addr[i])) begin
                n_bad++; $display("FAIL reset_read[%0d]: got %h want %h", sweep_addr[i], bus.CP0Out, m_read(sweep_addr[i]));
            end
        end
        n_cmp++;
        if ({bus.Req, bus.TimerIRQ, bus.EPCOut} !== 34'd0) begin
            n_bad++; $display("FAIL reset_outs: got req=%b ti=%b epc=%h want 0", bus.Req, bus.TimerIRQ, bus.EPCOut);
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_interrupt();
        wr(5'd12, 32'h0000_0401);
        bus.HWInt = 6'b000001; bus.VPC = 32'h3004; bus.BDIn = 1; #1;
        n_cmp++;
        if (bus.Req !== 1'b1) begin n_bad++; $display("FAIL int_req: got %b want 1", bus.Req); end
        step();
        bus.BDIn = 0; bus.CP0Add = 5'd13; #1;
        n_cmp++;
        if (bus.CP0Out !== 32'h8000_0400 || bus.CP0Out !== m_read(5'd13)) begin
            n_bad++; $display("FAIL int_cause: got %h want %h", bus.CP0Out, 32'h8000_0400);
        end
        n_cmp++;
        if (bus.EPCOut !== 32'h3004) begin n_bad++; $display("FAIL int_epc: got %h want 00003004", bus.EPCOut); end
        bus.CP0Add = 5'd12; #1;
        n_cmp++;
        if (bus.CP0Out !== m_read(5'd12) || bus.CP0Out[1] !== 1'b1) begin
            n_bad++; $display("FAIL int_sr_exl: got %h want %h", bus.CP0Out, m_read(5'd12));
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (bus.Req !== 1'b0) begin n_bad++; $display("FAIL int_held_off: got %b want 0", bus.Req); end
            step(); bus.HWInt = 6'b000001;
        end
        idle(); bus.EXLClr = 1; step(); idle();
        bus.CP0Add = 5'd12; #1;
        n_cmp++;
        if (bus.CP0Out !== 32'h0000_0401) begin n_bad++; $display("FAIL eret_sr: got %h want 00000401", bus.CP0Out); end
    endtask

    task automatic test_exception();
        logic [31:0] epc_before;
        idle(); bus.ExcCodeIn = 5'd4; bus.BadVAddrIn = 32'h1001; bus.VPC = 32'h4000; #1;
        n_cmp++;
        if (bus.Req !== 1'b1) begin n_bad++; $display("FAIL exc_req: got %b want 1", bus.Req); end
        step(); idle();
        bus.CP0Add = 5'd13; #1;
        n_cmp++;
        if (bus.CP0Out[6:2] !== 5'd4 || bus.CP0Out !== m_read(5'd13)) begin
            n_bad++; $display("FAIL exc_cause: got %h want %h", bus.CP0Out, m_read(5'd13));
        end
        bus.CP0Add = 5'd8; #1;
        n_cmp++;
        if (bus.CP0Out !== 32'h1001) begin n_bad++; $display("FAIL exc_badv: got %h want 00001001", bus.CP0Out); end
        bus.EXLClr = 1; step(); idle();
        epc_before = m_epc;
        bus.ExcCodeIn = 5'd9; bus.BadVAddrIn = 32'hDEAD_BEEF; bus.VPC = 32'h4444; #1;
        n_cmp++;
        if (bus.Req !== 1'b0) begin n_bad++; $display("FAIL masked_req: got %b want 0", bus.Req); end
        step(); idle();
        bus.CP0Add = 5'd8; #1;
        n_cmp++;
        if (bus.CP0Out !== 32'h1001) begin n_bad++; $display("FAIL masked_badv: got %h want 00001001", bus.CP0Out); end
        n_cmp++;
        if (bus.EPCOut !== epc_before) begin n_bad++; $display("FAIL masked_epc: got %h want %h", bus.EPCOut, epc_before); end
    endtask

    task automatic test_timer();
        int t;
        wr(5'd12, 32'h0);
        wr(5'd9, 32'h0);        t = 0;
        wr(5'd11, 32'd3);       t++;
        wr(5'd12, 32'h0000_8001); t++;
        while (t < 40) begin
            #1;
            n_cmp++;
            if (bus.TimerIRQ !== m_ti) begin n_bad++; $display("FAIL timer_ti@%0d: got %b want %b", t, bus.TimerIRQ, m_ti); end
            if (bus.TimerIRQ === 1'b1) break;
            step(); t++;
        end
        n_cmp++;
        if (t != 12) begin n_bad++; $display("FAIL timer_latency: got %0d want 12 cycles", t); end
        bus.CP0Add = 5'd9; #1;
        n_cmp++;
        if (bus.CP0Out !== 32'd3) begin n_bad++; $display("FAIL timer_count: got %h want 3", bus.CP0Out); end
        n_cmp++;
        if (bus.Req !== 1'b1) begin n_bad++; $display("FAIL timer_req: got %b want 1", bus.Req); end
        step();                          // interrupt taken, EXL set
        wr(5'd11, 32'd100);
        #1;
        n_cmp++;
        if (bus.TimerIRQ !== 1'b0) begin n_bad++; $display("FAIL timer_clear: got %b want 0", bus.TimerIRQ); end
        bus.EXLClr = 1; bus.WE = 1; bus.CP0Add = 5'd12; bus.CP0In = 32'hFFFF_0403;
        step(); idle();
        bus.CP0Add = 5'd12; #1;
        n_cmp++;
        if (bus.CP0Out !== 32'h0000_0403) begin n_bad++; $display("FAIL we_beats_eret: got %h want 00000403", bus.CP0Out); end
        bus.EXLClr = 1; step(); idle();
        wr(5'd12, 32'h0);
    endtask

    task automatic test_same_cycle();
        wr(5'd12, 32'h0000_0401);
        bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd12; bus.VPC = 32'h5008;
        bus.WE = 1; bus.CP0Add = 5'd14; bus.CP0In = 32'hFFFF; #1;
        n_cmp++;
        if (bus.Req !== 1'b1) begin n_bad++; $display("FAIL same_req: got %b want 1", bus.Req); end
        step(); idle();
        bus.CP0Add = 5'd13; #1;
        n_cmp++;
        if (bus.CP0Out[6:2] !== 5'd0 || bus.CP0Out !== m_read(5'd13)) begin
            n_bad++; $display("FAIL same_cause: got %h want %h", bus.CP0Out, m_read(5'd13));
        end
        n_cmp++;
        if (bus.EPCOut !== 32'h5008) begin n_bad++; $display("FAIL same_epc: got %h want 00005008", bus.EPCOut); end
        bus.EXLClr = 1; step(); idle();
        wr(5'd12, 32'h0);
    endtask

    task automatic test_wrap();
        int t;
        wr(5'd11, 32'h0);
        wr(5'd9, 32'hFFFF_FFFF);
        t = 0;
        bus.CP0Add = 5'd9; #1;
        n_cmp++;
        if (bus.CP0Out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_start: got %h want ffffffff", bus.CP0Out); end
        while (t < 10 && bus.CP0Out !== 32'h0) begin
            step(); t++; bus.CP0Add = 5'd9; #1;
        end
        n_cmp++;
        if (t != DIV) begin n_bad++; $display("FAIL wrap_latency: got %0d want %0d cycles", t, DIV); end
        n_cmp++;
        if (bus.TimerIRQ !== 1'b1 || m_ti !== 1'b1) begin n_bad++; $display("FAIL wrap_ti: got %b want 1", bus.TimerIRQ); end
        wr(5'd11, 32'h7FFF_FFFF);
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int n = 0; n < 400; n++) begin
            a = rnd_addr[$urandom_range(0, 8)];
            bus.WE         = ($urandom_range(0, 2) == 0);
            bus.CP0Add     = a;
            bus.CP0In      = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 30));
            bus.VPC        = $urandom;
            bus.BDIn       = 1'($urandom);
            bus.ExcCodeIn  = rnd_code[$urandom_range(0, 10)];
            bus.BadVAddrIn = $urandom;
            bus.HWInt      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            bus.EXLClr     = ($urandom_range(0, 5) == 0);
            #1;
            n_cmp++;
            if (bus.Req !== m_req() || bus.TimerIRQ !== m_ti || bus.EPCOut !== m_epc || bus.CP0Out !== m_read(a)) begin
                n_bad++;
                $display("FAIL rand#%0d a=%0d: got req=%b ti=%b epc=%h out=%h want req=%b ti=%b epc=%h out=%h",
                         n, a, bus.Req, bus.TimerIRQ, bus.EPCOut, bus.CP0Out, m_req(), m_ti, m_epc, m_read(a));
            end
            step();
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        idle();
        for (int k = 0; k < 4 && m_req(); k++) step();
        wr(5'd11, 32'hFFFF_0000);
        wr(5'd12, 32'h0000_0401);
        wr(5'd9, 32'd37);
        bus.HWInt = 6'b000001; bus.CP0Add = 5'd9; #1;
        n_cmp++;
        if (bus.CP0Out !== 32'd37 || bus.Req !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset: got count=%h req=%b want 37/1", bus.CP0Out, bus.Req);
        end
        rst_n = 1'b0; #1;
        m_reset();
        n_cmp++;
        if (bus.Req !== 1'b0) begin n_bad++; $display("FAIL async_reset_req: got %b want 0", bus.Req); end
        for (int i = 0; i < 10; i++) begin
            bus.CP0Add = sweep_addr[i]; #1;
            n_cmp++;
            if (bus.CP0Out !== m_read(sweep_addr[i])) begin
                n_bad++; $display("FAIL midrun_read[%0d]: got %h want %h", sweep_addr[i], bus.CP0Out, m_read(sweep_addr[i]));
            end
        end
        @(negedge clk);
        rst_n = 1'b1; idle();
        for (int k = 0; k < DIV; k++) step();
        bus.CP0Add = 5'd9; #1;
        n_cmp++;
        if (bus.CP0Out !== 32'd1 || bus.CP0Out !== m_count) begin
            n_bad++; $display("FAIL restart_count: got %h want 1", bus.CP0Out);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        idle();
        bus.VPC = 0; bus.BadVAddrIn = 0;
        test_reset();
        test_interrupt();
        test_exception();
        test_timer();
        test_same_cycle();
        test_wrap();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
